config_write_arbiter: RTL



---
 rtl/config_arb_pkg.sv | 21 ++
 rtl/config_write_arbiter_if.sv | 56 +++++
 rtl/config_arb_pacer.sv | 47 ++++
 rtl/config_write_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/config_arb_pkg.sv
// Shared definitions for the eFPGA configuration write arbiter: state encoding,
// owner encoding, word width and a counter-width helper.
package config_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } arb_state_t;

    localparam logic OWNER_FLASH = 1'b0;
    localparam logic OWNER_USB   = 1'b1;

    // Width able to hold 0..max_val; never narrower than one bit so a zero gap still elaborates.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/config_write_arbiter_if.sv
// Bus bundle between the two bitstream producers, the fabric config port and the arbiter.
// Optional word_count_o is present only when WORD_COUNT_EN is defined.
interface config_write_arbiter_if;
    import config_arb_pkg::*;

    // Handshake rule for both sources: a word moves on a cycle where valid && ready are
    // both high at the rising edge; ready never depends combinationally on valid.
    logic [WORD_W-1:0] flash_data_i;
    logic              flash_valid_i;
    logic              flash_last_i;
    logic              flash_ready_o;
    logic [WORD_W-1:0] usb_data_i;
    logic              usb_valid_i;
    logic              usb_last_i;
    logic              usb_ready_o;
    logic [WORD_W-1:0] write_data_o;
    logic              write_strobe_o;
    logic              busy_o;
    logic              owner_o;
    logic              timeout_o;
    arb_state_t        state_o;
`ifdef WORD_COUNT_EN
    logic [15:0]       word_count_o;

    modport slave (
        input  flash_data_i, flash_valid_i, flash_last_i,
        input  usb_data_i, usb_valid_i, usb_last_i,
        output flash_ready_o, usb_ready_o,
        output write_data_o, write_strobe_o, busy_o, owner_o, timeout_o, state_o,
        output word_count_o
    );

    modport master (
        output flash_data_i, flash_valid_i, flash_last_i,
        output usb_data_i, usb_valid_i, usb_last_i,
        input  flash_ready_o, usb_ready_o,
        input  write_data_o, write_strobe_o, busy_o, owner_o, timeout_o, state_o,
        input  word_count_o
    );
`else
    modport slave (
        input  flash_data_i, flash_valid_i, flash_last_i,
        input  usb_data_i, usb_valid_i, usb_last_i,
        output flash_ready_o, usb_ready_o,
        output write_data_o, write_strobe_o, busy_o, owner_o, timeout_o, state_o
    );

    modport master (
        output flash_data_i, flash_valid_i, flash_last_i,
        output usb_data_i, usb_valid_i, usb_last_i,
        input  flash_ready_o, usb_ready_o,
        input  write_data_o, write_strobe_o, busy_o, owner_o, timeout_o, state_o
    );
`endif

endinterface

// File: rtl/config_arb_pacer.sv
// Strobe pacing down-counter and saturating owner-idle counter for the config write arbiter.
module config_arb_pacer
    import config_arb_pkg::*;
#(
    parameter int STROBE_GAP     = 2,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic gap_load,
    input  logic idle_inc,
    input  logic idle_clear,
    output logic gap_done,
    output logic timeout_hit
);

    localparam int GAP_W  = cnt_width(STROBE_GAP);
    localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);

    logic [GAP_W-1:0]  gap_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            gap_cnt <= '0;
        end else if (gap_load) begin
            gap_cnt <= GAP_W'(STROBE_GAP);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            idle_cnt <= '0;
        end else if (idle_clear) begin
            idle_cnt <= '0;
        end else if (idle_inc && (idle_cnt != IDLE_W'(TIMEOUT_CYCLES))) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign gap_done    = (gap_cnt == GAP_W'(1));
    // Fires on the idle cycle whose increment makes the count reach TIMEOUT_CYCLES.
    assign timeout_hit = idle_inc && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/config_write_arbiter.sv
// Arbitrates the single eFPGA config write port between flash boot loader and USB path.
// Define WORD_COUNT_EN to add the per-session accepted word counter (word_count_o).
module config_write_arbiter
    import config_arb_pkg::*;
#(
    parameter int STROBE_GAP     = 2,
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int FLASH_PRIORITY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    config_write_arbiter_if.slave bus
);

    localparam bit HAS_GAP = (STROBE_GAP > 0);

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic              last_q;
    logic              strobe_q;
    logic              timeout_q;
    logic [WORD_W-1:0] data_q;

    logic              sel_valid, sel_last;
    logic [WORD_W-1:0] sel_data;
    logic              hs, grant, grant_owner;
    logic              gap_done, timeout_hit;

    // The non-owner is invisible for the whole session: only the owner's lane is selected.
    assign sel_valid = (owner_q == OWNER_USB) ? bus.usb_valid_i : bus.flash_valid_i;
    assign sel_data  = (owner_q == OWNER_USB) ? bus.usb_data_i  : bus.flash_data_i;
    assign sel_last  = (owner_q == OWNER_USB) ? bus.usb_last_i  : bus.flash_last_i;

    assign hs    = (state_q == ST_ACTIVE) && sel_valid;
    assign grant = (state_q == ST_IDLE) && (bus.flash_valid_i || bus.usb_valid_i);

    always_comb begin
        grant_owner = OWNER_FLASH;
        if (bus.flash_valid_i && bus.usb_valid_i) begin
            grant_owner = (FLASH_PRIORITY != 0) ? OWNER_FLASH : OWNER_USB;
        end else if (bus.usb_valid_i) begin
            grant_owner = OWNER_USB;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (hs) begin
                    if (HAS_GAP)       state_d = ST_GAP;
                    else if (sel_last) state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_done) state_d = last_q ? ST_IDLE : ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            owner_q   <= OWNER_FLASH;
            last_q    <= 1'b0;
            strobe_q  <= 1'b0;
            timeout_q <= 1'b0;
            data_q    <= '0;
        end else begin
            strobe_q  <= hs;
            timeout_q <= timeout_hit;
            if (grant) owner_q <= grant_owner;
            if (hs) begin
                data_q <= sel_data;
                last_q <= sel_last;
            end
        end
    end

    config_arb_pacer #(
        .STROBE_GAP     (STROBE_GAP),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_pacer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .gap_load    (hs && HAS_GAP),
        .idle_inc    ((state_q == ST_ACTIVE) && !hs),
        .idle_clear  (hs || (state_q == ST_IDLE)),
        .gap_done    (gap_done),
        .timeout_hit (timeout_hit)
    );

`ifdef WORD_COUNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            word_cnt_q <= '0;
        end else if (grant) begin
            word_cnt_q <= '0;
        end else if (hs && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign bus.word_count_o = word_cnt_q;
`endif

    // Readies decode from state and owner only.
    assign bus.flash_ready_o  = (state_q == ST_ACTIVE) && (owner_q == OWNER_FLASH);
    assign bus.usb_ready_o    = (state_q == ST_ACTIVE) && (owner_q == OWNER_USB);
    assign bus.write_data_o   = data_q;
    assign bus.write_strobe_o = strobe_q;
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.owner_o        = owner_q;
    assign bus.timeout_o      = timeout_q;
    assign bus.state_o        = state_q;

endmodule
